// File: rtl/reram_wb_pkg.sv
// Shared types and helpers for the ReRAM Wishbone bank controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default parameter values, address decode
// into {in_range, bank, row}, and the byte-enable merge used on writes.
package reram_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEF_NUM_BANKS      = 4;
  localparam int          DEF_WORDS_PER_BANK = 32;
  localparam logic [31:0] DEF_BASE_ADDR      = 32'h3000_0000;
  localparam int          DEF_READ_LAT       = 2;
  localparam int          DEF_WRITE_LAT      = 4;

  // Fields are sized for the largest legal configuration (16 banks);
  // the controller slices off the bits it actually needs.
  typedef struct packed {
    logic        in_range;
    logic [3:0]  bank;
    logic [29:0] row;
  } dec_t;

  // The base is aligned to the window, so "in range" is simply "offset has
  // no bits set above the window". An address below the base wraps to a
  // large offset and is rejected by the same test.
  function automatic dec_t decode_adr(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int          bank_bits,
                                      input int          row_bits);
    dec_t        d;
    logic [31:0] off;
    logic [31:0] win_mask;
    logic [29:0] word;
    off        = adr - base;
    win_mask   = ~((32'd1 << (bank_bits + row_bits + 2)) - 32'd1);
    word       = off[31:2];
    d.in_range = ((off & win_mask) == 32'd0);
    d.row      = word & ((30'd1 << row_bits) - 30'd1);
    d.bank     = 4'((word >> row_bits) & ((30'd1 << bank_bits) - 30'd1));
    return d;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reram_bank_array.sv
// One behavioural ReRAM bank: WORDS x 32-bit, byte-enable write, async read.
// Latency: write lands on the clock edge where we=1; read is combinational.
// Backpressure: none; the controller owns all sequencing.
//
// Ports: clk, we (write strobe), sel (byte enables), row (word index),
//        wdat (write data), rdat (read data at row).
// Storage has no reset: contents survive controller reset (non-volatile).
module reram_bank_array
  import reram_wb_pkg::*;
#(
  parameter int WORDS = DEF_WORDS_PER_BANK,
  parameter int ROW_W = $clog2(DEF_WORDS_PER_BANK)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [ROW_W-1:0] row,
  input  logic [31:0]      wdat,
  output logic [31:0]      rdat
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[row] <= byte_merge(mem[row], wdat, sel);
    end
  end

  assign rdat = mem[row];

endmodule

// File: rtl/reram_wb_bank_ctrl.sv
// Wishbone slave fronting NUM_BANKS ReRAM banks with range check and abort.
// Latency: response pulse LAT+1 cycles after the request is sampled (LAT = READ_LAT/WRITE_LAT).
// Backpressure: one request at a time; stb is ignored until the FSM returns to IDLE.
//
// Ports: wb_clk_i/wb_rst_i (sync active-high reset), wbs_stb_i/cyc_i/we_i/
//        sel_i/dat_i/adr_i (request), wbs_ack_o/err_o (one-cycle responses),
//        wbs_dat_o (last read data, held until the next read completes).
// Build option: define RERAM_WB_ERR_EN to answer out-of-range accesses with
// wbs_err_o; otherwise they are acked, writes dropped, and reads return 0.
module reram_wb_bank_ctrl
  import reram_wb_pkg::*;
#(
  parameter int          NUM_BANKS      = DEF_NUM_BANKS,
  parameter int          WORDS_PER_BANK = DEF_WORDS_PER_BANK,
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter int          READ_LAT       = DEF_READ_LAT,
  parameter int          WRITE_LAT      = DEF_WRITE_LAT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = $clog2(WORDS_PER_BANK);
  localparam int MAX_LAT   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ld;
  logic               resp_go;

  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        wdat_q;
  logic [BANK_W-1:0]  bank_q;
  logic [ROW_W-1:0]   row_q;
  logic               inr_q;

  logic               ack_q, ack_d;
  logic               err_d;
  logic [31:0]        rdat_q;
  logic               rd_load;
  logic [31:0]        rd_next;

  dec_t               dec;
  logic [31:0]        bank_rdat [NUM_BANKS];
  logic [31:0]        rd_word;

  assign dec = decode_adr(wbs_adr_i, BASE_ADDR, BANK_BITS, ROW_W);

  // Only the low bank/row bits matter for this configuration.
  logic unused_dec;
  assign unused_dec = ^{dec.bank, dec.row};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state / control ----------------
  // Abort (cyc low) takes priority over the counter reaching zero, so a
  // master that drops cyc in the last BUSY cycle still gets no response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_ld  = 1'b0;
    resp_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          req_ld  = 1'b1;
          state_d = BUSY;
          cnt_d   = wbs_we_i ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- response selection ----------------
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_load = 1'b0;
    rd_next = rd_word;
`ifdef RERAM_WB_ERR_EN
    ack_d   = resp_go && inr_q;
    err_d   = resp_go && !inr_q;
    rd_load = resp_go && !we_q && inr_q;
`else
    ack_d   = resp_go;
    rd_load = resp_go && !we_q;
    rd_next = inr_q ? rd_word : 32'h0;
`endif
  end

  // ---------------- request latch and registered outputs ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
      bank_q <= '0;
      row_q  <= '0;
      inr_q  <= 1'b0;
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= ack_d;
      if (req_ld) begin
        we_q   <= wbs_we_i;
        sel_q  <= wbs_sel_i;
        wdat_q <= wbs_dat_i;
        bank_q <= dec.bank[BANK_W-1:0];
        row_q  <= dec.row[ROW_W-1:0];
        inr_q  <= dec.in_range;
      end
      if (rd_load) begin
        rdat_q <= rd_next;
      end
    end
  end

`ifdef RERAM_WB_ERR_EN
  logic err_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign wbs_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
  assign wbs_err_o  = 1'b0;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;

  // ---------------- banks ----------------
  // The write is committed at the edge that ends DONE, so the ack the master
  // sees coincides with the cycle the data becomes visible to the next read.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = (state_q == DONE) && we_q && inr_q && (bank_q == BANK_W'(b));
    reram_bank_array #(
      .WORDS (WORDS_PER_BANK),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk  (wb_clk_i),
      .we   (bank_we),
      .sel  (sel_q),
      .row  (row_q),
      .wdat (wdat_q),
      .rdat (bank_rdat[b])
    );
  end

  assign rd_word = bank_rdat[bank_q];

endmodule

// File: tb/tb_reram_wb_bank_ctrl.sv
// Directed self-checking bench for reram_wb_bank_ctrl (default parameters).
module tb_reram_wb_bank_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_in, adr;
  logic        ack, err;
  logic [31:0] dat_out;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  reram_wb_bank_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_in),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_err_o (err),
    .wbs_dat_o (dat_out)
  );

  // Issues one request and waits (bounded) for ack/err. lat is the number of
  // falling edges after the sampling edge at which the response is seen.
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat,
                        output logic got_ack, output logic got_err);
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_in = d; sel = s;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = i; got_ack = ack; got_err = err;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (lat == 0) begin
      cmp_cnt++; mis_cnt++;
      $display("FAIL bus_timeout adr=%h: no response within 20 cycles", a);
    end
  endtask

  task automatic test_preload();
    int lat; logic a, e;
    bus_op(1'b1, BASE + 32'h20,  32'hA5A5_A5A5, 4'hF, lat, a, e);
    bus_op(1'b1, BASE + 32'h0,   32'h0, 4'hF, lat, a, e);
    bus_op(1'b1, BASE + 32'h10,  32'h0, 4'hF, lat, a, e);
    bus_op(1'b1, BASE + 32'h84,  32'h0, 4'hF, lat, a, e);
    bus_op(1'b1, BASE + 32'h1FC, 32'h0, 4'hF, lat, a, e);
    bus_op(1'b0, BASE + 32'h20,  32'h0, 4'hF, lat, a, e);
    cmp_cnt++;
    if (dat_out !== 32'hA5A5_A5A5) begin
      mis_cnt++; $display("FAIL preload_rd got=%h exp=a5a5a5a5", dat_out);
    end
  endtask

  task automatic test_reset();
    int lat; logic a, e;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_cnt++; if (ack !== 1'b0) begin mis_cnt++; $display("FAIL rst_ack got=%b exp=0", ack); end
    cmp_cnt++; if (err !== 1'b0) begin mis_cnt++; $display("FAIL rst_err got=%b exp=0", err); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL rst_dat got=%h exp=0", dat_out); end
    bus_op(1'b0, BASE, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (lat != 3) begin mis_cnt++; $display("FAIL rd0_lat got=%0d exp=3", lat); end
    cmp_cnt++; if (a !== 1'b1) begin mis_cnt++; $display("FAIL rd0_ack got=%b exp=1", a); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL rd0_dat got=%h exp=0", dat_out); end
  endtask

  task automatic test_byte_write();
    int lat; logic a, e;
    bus_op(1'b1, BASE + 32'h84, 32'hDEAD_BEEF, 4'hF, lat, a, e);
    cmp_cnt++; if (lat != 5 || a !== 1'b1) begin mis_cnt++; $display("FAIL wr_full lat=%0d ack=%b exp lat=5 ack=1", lat, a); end
    bus_op(1'b1, BASE + 32'h84, 32'h0000_1200, 4'b0010, lat, a, e);
    cmp_cnt++; if (lat != 5 || a !== 1'b1) begin mis_cnt++; $display("FAIL wr_byte lat=%0d ack=%b exp lat=5 ack=1", lat, a); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL wr_keeps_dat got=%h exp=0", dat_out); end
    bus_op(1'b1, BASE + 32'h84, 32'hFFFF_FFFF, 4'b0000, lat, a, e);
    cmp_cnt++; if (a !== 1'b1) begin mis_cnt++; $display("FAIL wr_sel0_ack got=%b exp=1", a); end
    bus_op(1'b0, BASE + 32'h84, 32'h0, 4'b0001, lat, a, e);
    cmp_cnt++; if (lat != 3) begin mis_cnt++; $display("FAIL rd84_lat got=%0d exp=3", lat); end
    cmp_cnt++; if (dat_out !== 32'hDEAD_12EF) begin mis_cnt++; $display("FAIL rd84_dat got=%h exp=dead12ef", dat_out); end
  endtask

  task automatic test_range();
    int lat; logic a, e;
    bus_op(1'b1, BASE + 32'h1FC, 32'h1234_5678, 4'hF, lat, a, e);
    cmp_cnt++; if (a !== 1'b1 || e !== 1'b0) begin mis_cnt++; $display("FAIL last_wr ack=%b err=%b exp 1/0", a, e); end
    bus_op(1'b0, BASE + 32'h1FC, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (dat_out !== 32'h1234_5678) begin mis_cnt++; $display("FAIL last_rd got=%h exp=12345678", dat_out); end
    bus_op(1'b0, BASE + 32'h200, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (lat != 3) begin mis_cnt++; $display("FAIL oor_rd_lat got=%0d exp=3", lat); end
`ifdef RERAM_WB_ERR_EN
    cmp_cnt++; if (a !== 1'b0 || e !== 1'b1) begin mis_cnt++; $display("FAIL oor_rd_resp ack=%b err=%b exp 0/1", a, e); end
    cmp_cnt++; if (dat_out !== 32'h1234_5678) begin mis_cnt++; $display("FAIL oor_rd_dat got=%h exp=12345678", dat_out); end
`else
    cmp_cnt++; if (a !== 1'b1 || e !== 1'b0) begin mis_cnt++; $display("FAIL oor_rd_resp ack=%b err=%b exp 1/0", a, e); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL oor_rd_dat got=%h exp=0", dat_out); end
`endif
    // An out-of-range write must not alias onto word 0.
    bus_op(1'b1, BASE + 32'h200, 32'h0BAD_0BAD, 4'hF, lat, a, e);
    cmp_cnt++; if (lat != 5) begin mis_cnt++; $display("FAIL oor_wr_lat got=%0d exp=5", lat); end
    bus_op(1'b0, BASE, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL oor_wr_alias got=%h exp=0", dat_out); end
  endtask

  task automatic test_abort();
    int lat; int seen; logic a, e;
    // Write aborted in the second BUSY cycle.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat_in = 32'h1; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); stb = 1'b0; cyc = 1'b0; we = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (ack || err) seen++;
    end
    cmp_cnt++; if (seen != 0) begin mis_cnt++; $display("FAIL abort_wr_resp got=%0d exp=0", seen); end
    bus_op(1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (lat != 3) begin mis_cnt++; $display("FAIL abort_idle_lat got=%0d exp=3", lat); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL abort_wr_mem got=%h exp=0", dat_out); end
    // Read aborted in its first BUSY cycle leaves dat_o alone.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h84; sel = 4'hF;
    @(posedge clk);
    @(negedge clk); stb = 1'b0; cyc = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (ack || err) seen++;
    end
    cmp_cnt++; if (seen != 0) begin mis_cnt++; $display("FAIL abort_rd_resp got=%0d exp=0", seen); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL abort_rd_dat got=%h exp=0", dat_out); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic a, e;
    bus_op(1'b0, BASE + 32'h84, 32'h0, 4'hF, lat, a, e);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h20; dat_in = 32'hCAFE_F00D; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    cmp_cnt++; if (ack !== 1'b0 || err !== 1'b0) begin mis_cnt++; $display("FAIL midrst_resp ack=%b err=%b exp 0/0", ack, err); end
    cmp_cnt++; if (dat_out !== 32'h0) begin mis_cnt++; $display("FAIL midrst_dat got=%h exp=0", dat_out); end
    bus_op(1'b0, BASE + 32'h20, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (dat_out !== 32'hA5A5_A5A5) begin mis_cnt++; $display("FAIL midrst_mem got=%h exp=a5a5a5a5", dat_out); end
    bus_op(1'b0, BASE + 32'h1FC, 32'h0, 4'hF, lat, a, e);
    cmp_cnt++; if (dat_out !== 32'h1234_5678) begin mis_cnt++; $display("FAIL persist_mem got=%h exp=12345678", dat_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] expd  [3];
    int          t     [3];
    logic [31:0] got   [3];
    int          k;
    int          extra;
    addrs[0] = BASE + 32'h84;  expd[0] = 32'hDEAD_12EF;
    addrs[1] = BASE + 32'h1FC; expd[1] = 32'h1234_5678;
    addrs[2] = BASE + 32'h20;  expd[2] = 32'hA5A5_A5A5;
    for (int i = 0; i < 3; i++) begin t[i] = 0; got[i] = 32'h0; end
    k = 0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = addrs[0];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack) begin
        t[k] = c; got[k] = dat_out; k++;
        if (k == 3) break;
        adr = addrs[k];
      end
    end
    stb = 1'b0; cyc = 1'b0;
    cmp_cnt++; if (k != 3) begin mis_cnt++; $display("FAIL b2b_count got=%0d exp=3", k); end
    cmp_cnt++; if (t[0] != 3) begin mis_cnt++; $display("FAIL b2b_first got=%0d exp=3", t[0]); end
    cmp_cnt++; if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
      mis_cnt++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", t[1] - t[0], t[2] - t[1]);
    end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if (got[i] !== expd[i]) begin mis_cnt++; $display("FAIL b2b_dat%0d got=%h exp=%h", i, got[i], expd[i]); end
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (ack || err) extra++;
    end
    cmp_cnt++; if (extra != 0) begin mis_cnt++; $display("FAIL b2b_extra got=%0d exp=0", extra); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; dat_in = 32'h0; adr = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_preload();
    test_reset();
    test_byte_write();
    test_range();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
